id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameters: DATA_BUS_SIZE, default 32, data/PC width; REG_ADDR_BUS_SIZE, default 5, register index width; FUNCT_BUS_SIZE, default 6, funct width; OP_ALU_BUS_SIZE, default 2, ALU-op width.
REQ-002 SHALL have ports (name direction width meaning):
- i_clk  in  1  single clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  debug-unit step enable; 0 holds all state
- i_stall  in  1  load-use hazard; insert control bubble
- i_flush  in  1  branch taken; insert full bubble
- i_valid  in  1  ID holds a real instruction
- i_halt  in  1  ID instruction is HALT
- i_wb_reg_write, i_wb_mem_to_reg, i_mem_branch, i_mem_read, i_mem_write, i_ex_dest, i_ex_alu_src  in  1 each  main-control outputs
- i_ex_alu_op  in  OP_ALU_BUS_SIZE  main-control ALU op
- i_pc_next, i_rs_data, i_rt_data, i_imm  in  DATA_BUS_SIZE each  PC+4, read data, sign-extended immediate
- i_rs, i_rt, i_rd  in  REG_ADDR_BUS_SIZE each  register indices
- i_funct  in  FUNCT_BUS_SIZE  funct field
- o_<each control/data input above>  out  same width  registered copy
- o_valid  out  1  EX holds a real instruction
- o_halt  out  1  EX holds the HALT instruction
- o_end_of_program  out  1  pipeline drained after HALT; sticky

Function
REQ-003 SHALL be registers only: every output driven from a flop, no input-to-output path.
REQ-004 SHALL apply per-edge priority: i_enable=0 > i_flush > i_stall > normal capture.
REQ-005 i_enable=0: all registers, FSM state and counter hold.
REQ-006 Flush: all outputs (control, data, indices, o_valid, o_halt) load 0.
REQ-007 Stall: 8 control outputs, o_valid, o_halt load 0; data/index outputs capture inputs.
REQ-008 Normal capture in RUN: all outputs load inputs; o_valid<=i_valid; o_halt<=i_halt&i_valid.
REQ-009 Captured HALT: control outputs load 0 regardless of inputs (travels as NOP).
REQ-010 FSM states RUN, DRAIN, DONE; reset state RUN.
REQ-011 RUN->DRAIN on enabled edge capturing HALT (i_halt=1, i_valid=1, no flush/stall); 2-bit drain counter loads 0.
REQ-012 DRAIN/DONE: every enabled edge treated as flush (full bubble) irrespective of inputs.
REQ-013 DRAIN: counter increments per enabled edge; on edge where counter==2, go DONE (3 enabled edges after HALT capture, covering EX, MEM, WB).
REQ-014 DONE: o_end_of_program=1, held until reset; otherwise 0.
REQ-015 HALT with i_flush or i_stall same edge: HALT discarded, FSM stays RUN.
REQ-016 i_valid=0 with i_halt=1: ignored, no transition.
REQ-017 Capture latency exactly one enabled edge.

Reset
REQ-018 i_reset=0 SHALL asynchronously clear all outputs to 0 and set FSM RUN, counter 0, without waiting for clock.
REQ-019 Reset mid-DRAIN or in DONE SHALL return to RUN with o_end_of_program=0; first enabled edge after release performs normal capture.

Verification
REQ-020 Bench SHALL cover:
- lw controls (reg_write=1, mem_read=1, others 0, alu_op=00), i_rs_data=0x0000_00AA, i_valid=1, one edge -> same values on outputs, o_valid=1.
- Same stimulus, i_stall=1 -> 8 controls 0, o_valid=0, o_rs_data=0x0000_00AA.
- R-type controls (reg_write=1, ex_dest=1, alu_op=10), i_flush=1 and i_stall=1 -> all outputs 0.
- i_enable=0 for 3 edges with changing inputs -> outputs unchanged from prior capture.
- HALT (i_halt=1, i_valid=1, i_mem_write=1) -> o_halt=1, o_mem_write=0; next 2 edges o_end_of_program=0, after 3rd edge 1; stays 1 with new valid inputs; outputs remain 0.
- In DRAIN, pull i_reset low between clock edges -> outputs 0 immediately; after release, lw capture works, o_end_of_program=0.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with HALT drain tracking.
// Captures decode-stage control and data into the execute stage. Flush
// and stall insert bubbles. A captured HALT starts a three-edge drain
// (EX, MEM, WB), after which o_end_of_program stays set until reset.
module id_ex_register #(
  parameter int DATA_BUS_SIZE     = 32,
  parameter int REG_ADDR_BUS_SIZE = 5,
  parameter int FUNCT_BUS_SIZE    = 6,
  parameter int OP_ALU_BUS_SIZE   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_stall,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic                         i_halt,
  input  logic                         i_wb_reg_write,
  input  logic                         i_wb_mem_to_reg,
  input  logic                         i_mem_branch,
  input  logic                         i_mem_read,
  input  logic                         i_mem_write,
  input  logic                         i_ex_dest,
  input  logic                         i_ex_alu_src,
  input  logic [OP_ALU_BUS_SIZE-1:0]   i_ex_alu_op,
  input  logic [DATA_BUS_SIZE-1:0]     i_pc_next,
  input  logic [DATA_BUS_SIZE-1:0]     i_rs_data,
  input  logic [DATA_BUS_SIZE-1:0]     i_rt_data,
  input  logic [DATA_BUS_SIZE-1:0]     i_imm,
  input  logic [REG_ADDR_BUS_SIZE-1:0] i_rs,
  input  logic [REG_ADDR_BUS_SIZE-1:0] i_rt,
  input  logic [REG_ADDR_BUS_SIZE-1:0] i_rd,
  input  logic [FUNCT_BUS_SIZE-1:0]    i_funct,
  output logic                         o_wb_reg_write,
  output logic                         o_wb_mem_to_reg,
  output logic                         o_mem_branch,
  output logic                         o_mem_read,
  output logic                         o_mem_write,
  output logic                         o_ex_dest,
  output logic                         o_ex_alu_src,
  output logic [OP_ALU_BUS_SIZE-1:0]   o_ex_alu_op,
  output logic [DATA_BUS_SIZE-1:0]     o_pc_next,
  output logic [DATA_BUS_SIZE-1:0]     o_rs_data,
  output logic [DATA_BUS_SIZE-1:0]     o_rt_data,
  output logic [DATA_BUS_SIZE-1:0]     o_imm,
  output logic [REG_ADDR_BUS_SIZE-1:0] o_rs,
  output logic [REG_ADDR_BUS_SIZE-1:0] o_rt,
  output logic [REG_ADDR_BUS_SIZE-1:0] o_rd,
  output logic [FUNCT_BUS_SIZE-1:0]    o_funct,
  output logic                         o_valid,
  output logic                         o_halt,
  output logic                         o_end_of_program
);

  localparam int CTRL_W = 7 + OP_ALU_BUS_SIZE;
  localparam int DATA_W = 4 * DATA_BUS_SIZE + 3 * REG_ADDR_BUS_SIZE + FUNCT_BUS_SIZE;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  drain_cnt, drain_cnt_nxt;
  logic        do_flush, do_stall, halt_capture;

  logic [CTRL_W-1:0] ctrl_in, ctrl_q;
  logic [DATA_W-1:0] data_in, data_q;
  logic              valid_q, halt_q;

  assign ctrl_in = {i_wb_reg_write, i_wb_mem_to_reg, i_mem_branch, i_mem_read,
                    i_mem_write, i_ex_dest, i_ex_alu_src, i_ex_alu_op};
  assign data_in = {i_pc_next, i_rs_data, i_rt_data, i_imm,
                    i_rs, i_rt, i_rd, i_funct};

  assign {o_wb_reg_write, o_wb_mem_to_reg, o_mem_branch, o_mem_read,
          o_mem_write, o_ex_dest, o_ex_alu_src, o_ex_alu_op} = ctrl_q;
  assign {o_pc_next, o_rs_data, o_rt_data, o_imm,
          o_rs, o_rt, o_rd, o_funct} = data_q;
  assign o_valid          = valid_q;
  assign o_halt           = halt_q;
  assign o_end_of_program = (state == DONE);

  // Edge classification and drain FSM next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    do_flush      = i_flush || (state != RUN);
    do_stall      = !do_flush && i_stall;
    halt_capture  = !do_flush && !i_stall && i_valid && i_halt;
    unique case (state)
      RUN: begin
        if (halt_capture) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = 2'd0;
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) state_nxt = DONE;
        else                   drain_cnt_nxt = drain_cnt + 2'd1;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Drain FSM state and counter; advance only on enabled edges.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: non-blocking assignments in sequential blocks so all flops update from pre-edge values.
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else if (i_enable) begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Pipeline payload: flush clears everything, stall clears control only,
  // a captured HALT passes through as a NOP with o_halt set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else if (i_enable) begin
      if (do_flush) begin
        ctrl_q  <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        halt_q  <= 1'b0;
      end else if (do_stall) begin
        ctrl_q  <= '0;
        data_q  <= data_in;
        valid_q <= 1'b0;
        halt_q  <= 1'b0;
      end else begin
        ctrl_q  <= halt_capture ? '0 : ctrl_in;
        data_q  <= data_in;
        valid_q <= i_valid;
        halt_q  <= i_halt && i_valid;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized self-checking bench for id_ex_register, with directed
// scenarios for the load, stall, flush, hold, HALT drain and reset cases.
module tb_id_ex_register;

  typedef struct packed {
    logic        wb_reg_write, wb_mem_to_reg, mem_branch, mem_read;
    logic        mem_write, ex_dest, ex_alu_src;
    logic [1:0]  ex_alu_op;
    logic [31:0] pc_next, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        valid, halt;
  } bund_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  enable = 1'b0, stall = 1'b0, flush = 1'b0;
  bund_t drv = '0;
  bund_t obs;
  logic  eop;

  // Reference model: what the EX stage should show, plus drain bookkeeping.
  bund_t exp_q;
  bit    m_halted;
  int    m_edges_after_halt;
  bit    m_eop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_register dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(enable), .i_stall(stall),
    .i_flush(flush), .i_valid(drv.valid), .i_halt(drv.halt),
    .i_wb_reg_write(drv.wb_reg_write), .i_wb_mem_to_reg(drv.wb_mem_to_reg),
    .i_mem_branch(drv.mem_branch), .i_mem_read(drv.mem_read),
    .i_mem_write(drv.mem_write), .i_ex_dest(drv.ex_dest),
    .i_ex_alu_src(drv.ex_alu_src), .i_ex_alu_op(drv.ex_alu_op),
    .i_pc_next(drv.pc_next), .i_rs_data(drv.rs_data), .i_rt_data(drv.rt_data),
    .i_imm(drv.imm), .i_rs(drv.rs), .i_rt(drv.rt), .i_rd(drv.rd),
    .i_funct(drv.funct),
    .o_wb_reg_write(obs.wb_reg_write), .o_wb_mem_to_reg(obs.wb_mem_to_reg),
    .o_mem_branch(obs.mem_branch), .o_mem_read(obs.mem_read),
    .o_mem_write(obs.mem_write), .o_ex_dest(obs.ex_dest),
    .o_ex_alu_src(obs.ex_alu_src), .o_ex_alu_op(obs.ex_alu_op),
    .o_pc_next(obs.pc_next), .o_rs_data(obs.rs_data), .o_rt_data(obs.rt_data),
    .o_imm(obs.imm), .o_rs(obs.rs), .o_rt(obs.rt), .o_rd(obs.rd),
    .o_funct(obs.funct), .o_valid(obs.valid), .o_halt(obs.halt),
    .o_end_of_program(eop)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_of(bund_t b);
    return {b.wb_reg_write, b.wb_mem_to_reg, b.mem_branch, b.mem_read,
            b.mem_write, b.ex_dest, b.ex_alu_src, b.ex_alu_op};
  endfunction

  function automatic bund_t strip_ctrl(bund_t b);
    bund_t r = b;
    r.wb_reg_write = 0; r.wb_mem_to_reg = 0; r.mem_branch = 0; r.mem_read = 0;
    r.mem_write = 0; r.ex_dest = 0; r.ex_alu_src = 0; r.ex_alu_op = '0;
    return r;
  endfunction

  function automatic bund_t rand_bund();
    bund_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  task automatic model_reset();
    exp_q = '0;
    m_halted = 0;
    m_edges_after_halt = 0;
    m_eop = 0;
  endtask

  // One rising edge as seen by the model, from the inputs currently driven.
  task automatic model_edge();
    bund_t nx;
    if (!enable) return;
    if (m_halted) begin
      exp_q = '0;
      m_edges_after_halt++;
      if (m_edges_after_halt >= 3) m_eop = 1;
    end else if (flush) begin
      exp_q = '0;
    end else if (stall) begin
      nx = strip_ctrl(drv);
      nx.valid = 0;
      nx.halt  = 0;
      exp_q = nx;
    end else begin
      nx = drv;
      nx.halt = drv.halt & drv.valid;
      if (drv.halt && drv.valid) begin
        nx = strip_ctrl(nx);
        m_halted = 1;
        m_edges_after_halt = 0;
      end
      exp_q = nx;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".ctrl"},  {55'd0, ctrl_of(obs)}, {55'd0, ctrl_of(exp_q)});
    check({tag, ".pc"},    {32'd0, obs.pc_next}, {32'd0, exp_q.pc_next});
    check({tag, ".rsd"},   {32'd0, obs.rs_data}, {32'd0, exp_q.rs_data});
    check({tag, ".rtd"},   {32'd0, obs.rt_data}, {32'd0, exp_q.rt_data});
    check({tag, ".imm"},   {32'd0, obs.imm},     {32'd0, exp_q.imm});
    check({tag, ".idx"},   {43'd0, obs.rs, obs.rt, obs.rd, obs.funct},
                           {43'd0, exp_q.rs, exp_q.rt, exp_q.rd, exp_q.funct});
    check({tag, ".vh"},    {62'd0, obs.valid, obs.halt}, {62'd0, exp_q.valid, exp_q.halt});
    check({tag, ".eop"},   {63'd0, eop}, {63'd0, m_eop});
  endtask

  // Apply current inputs across one edge, then sample 1 ns later.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_model(tag);
    check({tag, ".zero"}, {63'd0, |obs}, 64'd0);
    #1 rst_n = 1'b1;
  endtask

  function automatic bund_t lw_bund();
    bund_t b = rand_bund();
    b = strip_ctrl(b);
    b.wb_reg_write = 1;
    b.mem_read     = 1;
    b.rs_data      = 32'h0000_00AA;
    b.valid        = 1;
    b.halt         = 0;
    return b;
  endfunction

  initial begin
    bund_t held;
    model_reset();
    #3;
    compare_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load word capture.
    enable = 1; drv = lw_bund();
    step("lw");
    check("lw.ctrl_const", {55'd0, ctrl_of(obs)}, {55'd0, 9'b1_0_0_1_0_0_0_00});
    check("lw.rsd_const", {32'd0, obs.rs_data}, 64'h0000_00AA);
    check("lw.valid_const", {63'd0, obs.valid}, 64'd1);

    // Same stimulus under stall.
    stall = 1;
    step("stall");
    check("stall.ctrl_const", {55'd0, ctrl_of(obs)}, 64'd0);
    check("stall.rsd_const", {32'd0, obs.rs_data}, 64'h0000_00AA);

    // R-type with flush and stall together.
    drv = rand_bund(); drv = strip_ctrl(drv);
    drv.wb_reg_write = 1; drv.ex_dest = 1; drv.ex_alu_op = 2'b10;
    drv.valid = 1; drv.halt = 0; flush = 1;
    step("flush");
    check("flush.all_zero", {63'd0, |obs}, 64'd0);
    stall = 0; flush = 0;

    // Capture, then hold for three disabled edges with changing inputs.
    drv = lw_bund();
    step("pre_hold");
    held = obs;
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      drv = rand_bund(); flush = 1'($urandom); stall = 1'($urandom);
      step("hold");
    end
    check("hold.same", {63'd0, obs != held}, 64'd0);
    enable = 1; flush = 0; stall = 0;

    // HALT capture and drain.
    drv = rand_bund(); drv.halt = 1; drv.valid = 1; drv.mem_write = 1;
    step("halt");
    check("halt.o_halt", {63'd0, obs.halt}, 64'd1);
    check("halt.mem_write", {63'd0, obs.mem_write}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      drv = rand_bund();
      step("drain");
      check("drain.eop_const", {63'd0, eop}, (i == 2) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 2; i++) begin
      drv = lw_bund();
      step("done");
      check("done.eop_const", {63'd0, eop}, 64'd1);
      check("done.zero", {63'd0, |obs}, 64'd0);
    end

    // Reset in the middle of a drain.
    async_reset("rst_done");
    drv = rand_bund(); drv.halt = 1; drv.valid = 1;
    step("halt2");
    drv = rand_bund();
    step("drain2");
    async_reset("rst_drain");
    drv = lw_bund();
    step("lw_after_rst");
    check("lw_after_rst.valid", {63'd0, obs.valid}, 64'd1);
    check("lw_after_rst.eop", {63'd0, eop}, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drv = rand_bund();
      drv.valid = ($urandom_range(0, 9) < 8);
      drv.halt  = ($urandom_range(0, 99) < 4);
      enable    = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 99) < 15);
      step("rand");
      if ($urandom_range(0, 99) < 2) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
